// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module : fifo_arb_pkg
// Brief  : Shared types, default sizes and the rotating-priority helper for
//          the FIFO push arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int MAX_REQ       = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Returns {valid, index}: first set bit of req scanning upward from last+1,
  // wrapping modulo n. Scanning far-to-near lets the nearest hit win.
  function automatic logic [3:0] rotate_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last,
    input int unsigned        n
  );
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = MAX_REQ; k >= 1; k--) begin
      idx = (32'(last) + k) % n;
      if (k <= n && req[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; winner is the first requester
//          after rr_last, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [3:0] w_pick;

  assign w_pick = rotate_pick(8'(req), 3'(rr_last), NUM_REQ);
  assign valid  = w_pick[3];
  assign winner = IW'(w_pick[2:0]);

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// ============================================================================
// Module : fifo_push_arbiter
// Brief  : Round-robin, burst-granular sharing of one FIFO write port among
//          NUM_REQ producers. Optional macro FIFO_ARB_THRESH_THROTTLE_EN
//          holds off new grants while the FIFO threshold flag is high.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       fifo_push,
  output logic [DW-1:0]              fifo_din,
  input  logic                       fifo_full,
  input  logic                       fifo_thre,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int             IW          = $clog2(NUM_REQ);
  localparam int             BW          = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]  C_LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0]  C_RR_RESET  = IW'(NUM_REQ - 1);

  state_t         r_state;
  logic [IW-1:0]  r_rr_last;
  logic [BW-1:0]  r_beat_cnt;

  logic           w_valid;
  logic [IW-1:0]  w_winner;
  logic           w_arb_ok;
  logic           w_own_req;
  logic           w_exit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req     (req),
    .rr_last (r_rr_last),
    .valid   (w_valid),
    .winner  (w_winner)
  );

`ifdef FIFO_ARB_THRESH_THROTTLE_EN
  assign w_arb_ok = ~fifo_thre;
`else
  logic w_unused_thre;
  assign w_unused_thre = fifo_thre;
  assign w_arb_ok      = 1'b1;
`endif

  // fifo_full is registered inside the FIFO, so gating the push on it here
  // is exact and never overruns.
  assign busy      = (r_state == XFER);
  assign w_own_req = req[owner];
  assign fifo_push = busy & w_own_req & ~fifo_full;
  assign fifo_din  = req_data[owner*DW +: DW];

  always_comb begin
    ack        = '0;
    ack[owner] = fifo_push;
  end

  assign w_exit = busy & (~w_own_req |
                          (fifo_push & (req_last[owner] | (r_beat_cnt == C_LAST_BEAT))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      r_beat_cnt <= '0;
      r_rr_last  <= C_RR_RESET;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid & w_arb_ok) begin
            r_state    <= XFER;
            gnt        <= NUM_REQ'(1) << w_winner;
            owner      <= w_winner;
            r_beat_cnt <= '0;
          end
        end
        XFER: begin
          if (fifo_push) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (w_exit) begin
            r_state   <= IDLE;
            gnt       <= '0;
            r_rr_last <= owner;
          end
        end
        default: begin
          r_state <= IDLE;
          gnt     <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// ============================================================================
// Module : tb_fifo_push_arbiter
// Brief  : Self-checking bench: directed scenarios plus randomized producers,
//          compared cycle by cycle against a transaction-level arbiter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_push_arbiter;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            fifo_push;
  logic [DW-1:0]   fifo_din;
  logic            fifo_full;
  logic            fifo_thre;
  logic [1:0]      owner;
  logic            busy;

  fifo_push_arbiter #(
    .NUM_REQ   (N),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .fifo_thre (fifo_thre),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_pushes = 0;

  // producers: words remaining in current burst and next data word
  int         rem [N];
  logic [7:0] seq [N];

  // arbiter model: who owns the port, beats moved, last served requester
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]             = (rem[i] > 0);
      req_last[i]        = (rem[i] == 1);
      req_data[i*DW +: DW] = seq[i];
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_beats = 0;
    m_rr    = N - 1;
  endtask

  // called just after a rising edge; checks the cycle then advances the model
  task automatic cycle();
    bit         e_push;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    bit         n_busy;
    int         n_owner, n_beats, n_rr;
    bit         may_grant;
    bit         found;
    int         cand;
    @(negedge clk);
    e_push = m_busy && req[m_owner] && !fifo_full;
    e_gnt  = m_busy ? 4'(1 << m_owner) : 4'b0;
    e_ack  = e_push ? 4'(1 << m_owner) : 4'b0;
    check("gnt",   gnt,       e_gnt);
    check("owner", owner,     m_owner);
    check("busy",  busy,      m_busy);
    check("push",  fifo_push, e_push);
    check("ack",   ack,       e_ack);
    if (m_busy) check("din", fifo_din, seq[m_owner]);
    if (fifo_push) dut_pushes++;

    n_busy = m_busy; n_owner = m_owner; n_beats = m_beats; n_rr = m_rr;
    if (!m_busy) begin
      may_grant = 1;
`ifdef FIFO_ARB_THRESH_THROTTLE_EN
      if (fifo_thre) may_grant = 0;
`endif
      found = 0;
      if (may_grant) begin
        for (int k = 1; k <= N; k++) begin
          cand = (m_rr + k) % N;
          if (!found && req[cand]) begin
            found   = 1;
            n_busy  = 1;
            n_owner = cand;
            n_beats = 0;
          end
        end
      end
    end else begin
      if (e_push) n_beats = m_beats + 1;
      if (!req[m_owner] || (e_push && (req_last[m_owner] || n_beats == MAX_BURST))) begin
        n_busy = 0;
        n_rr   = m_owner;
      end
    end

    @(posedge clk);
    #1;
    if (e_push) begin
      seq[m_owner] = seq[m_owner] + 8'd1;
      rem[m_owner] = rem[m_owner] - 1;
    end
    m_busy = n_busy; m_owner = n_owner; m_beats = n_beats; m_rr = n_rr;
    drive();
  endtask

  // entered just after a rising edge; reset must clear outputs at once
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_push", fifo_push, 1'b0);
    check("rst_ack",  ack,       4'b0);
    check("rst_gnt",  gnt,       4'b0);
    check("rst_busy", busy,      1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
  endtask

  initial begin
    int start;
    bit hit;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    fifo_thre = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 8'(i * 64);
    end
    drive();
    model_reset();
    #2;
    check("init_gnt",   gnt,       4'b0);
    check("init_owner", owner,     2'd0);
    check("init_busy",  busy,      1'b0);
    check("init_push",  fifo_push, 1'b0);
    check("init_ack",   ack,       4'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single requester, last on 3rd word
    rem[0] = 3;
    drive();
    start = dut_pushes;
    repeat (6) cycle();
    check("d1_pushes", dut_pushes - start, 3);

    // all requesting, bursts capped by MAX_BURST
    for (int i = 0; i < N; i++) rem[i] = 1000;
    drive();
    start = dut_pushes;
    repeat (25) cycle();
    check("d2_pushes", dut_pushes - start, 20);
    clear_reqs();
    repeat (2) cycle();

    // requester 2 stalled by full mid-burst
    rem[2] = 4;
    drive();
    start = dut_pushes;
    for (int k = 0; k < 14; k++) begin
      fifo_full = (k >= 3 && k < 8);
      cycle();
    end
    fifo_full = 1'b0;
    check("d3_pushes", dut_pushes - start, 4);

    // reset during requester 1's second beat
    clear_reqs();
    rem[1] = 1000;
    drive();
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      cycle();
      if (m_busy && m_owner == 1 && m_beats == 1) hit = 1;
    end
    check("d4_reach", hit, 1'b1);
    do_reset();
    rem[0] = 2;
    drive();
    cycle();
    check("d4_first_winner", gnt, 4'b0001);
    repeat (5) cycle();

    // owner drops request after one beat
    clear_reqs();
    repeat (3) cycle();
    rem[3] = 1000;
    drive();
    start = dut_pushes;
    for (int k = 0; k < 10 && dut_pushes == start; k++) cycle();
    check("d5_first_beat", dut_pushes - start, 1);
    rem[3] = 0;
    rem[0] = 2;
    drive();
    repeat (6) cycle();

    // threshold flag with a single request
    clear_reqs();
    repeat (2) cycle();
    fifo_thre = 1'b1;
    rem[1] = 2;
    drive();
    repeat (3) cycle();
    fifo_thre = 1'b0;
    repeat (5) cycle();

    // randomized producers, full/thre and occasional reset
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 3) == 0)
            rem[i] = ($urandom_range(0, 2) == 0) ? 1000 : int'($urandom_range(1, 6));
        end else if ($urandom_range(0, 39) == 0) begin
          rem[i] = 0;
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      fifo_thre = ($urandom_range(0, 4) == 0);
      drive();
      if ($urandom_range(0, 699) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the single 8-bit synchronous FIFO write port among NUM_REQ producers using round-robin, burst-granular arbitration.
- Drives the FIFO's push_in/din. Observes the FIFO's full and thre_trigger flags, so no producer ever pushes into a full FIFO (the FIFO's overrun flag stays low).
- Sits between the producer blocks and the FIFO. Producers never touch the FIFO directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, data width; must match the FIFO's din width.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held high while the requester has a word on req_data.
- req_data  in  NUM_REQ*DW  flattened data; slice i = req_data[i*DW +: DW].
- req_last  in  NUM_REQ  marks the final word of requester i's burst.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle.
- ack  out  NUM_REQ  word accepted this cycle (combinational); requester advances its data on ack.
- fifo_push  out  1  to FIFO push_in.
- fifo_din  out  DW  to FIFO din.
- fifo_full  in  1  FIFO full flag.
- fifo_thre  in  1  FIFO thre_trigger flag.
- owner  out  $clog2(NUM_REQ)  index of the current grantee; holds the last owner when idle.
- busy  out  1  high in XFER.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt=0; owner=0; beat_cnt=0.
  - Round-robin pointer rr_last=NUM_REQ-1, so requester 0 has top priority after reset.
  - fifo_push=0 and ack=0 immediately (combinational from state).
- Reset mid-burst: the burst is abandoned with no further push. Words already acked remain in the FIFO.
- FSM, two states:
  - IDLE: if any req (and not throttled, see Optional Feature):
    - pick the first set req scanning from rr_last+1 upward, wrapping modulo NUM_REQ;
    - next edge: gnt one-hot, owner=winner, beat_cnt=0, go XFER.
    - Otherwise stay in IDLE.
  - XFER:
    - fifo_push = req[owner] & ~fifo_full.
    - fifo_din = req_data slice[owner].
    - ack[owner] = fifo_push; all other ack bits are 0.
    - On a push, beat_cnt increments.
    - Return to IDLE (gnt=0, rr_last=owner) at the edge where any of these holds:
      - a push with req_last[owner];
      - a push with beat_cnt==MAX_BURST-1;
      - req[owner]==0, which terminates the burst with no push.
- Latency:
  - req rising in IDLE -> gnt next edge -> first push in the same cycle gnt is high (if not full).
  - Minimum 1 idle cycle between consecutive bursts (arbitration gap).
- Full stall: while fifo_full=1 in XFER there is no push and no ack, and beat_cnt holds. The grant is kept and the burst resumes when full clears.
  - fifo_full is registered in the FIFO, so the combinational check is exact.
- Only the granted requester is ever acked. req_data of non-owners is ignored.
- A single requester continuously requesting gets back-to-back bursts separated by a 1-cycle gap.
- Simultaneous last and MAX_BURST conditions: one exit, no double count.
- beat_cnt width is $clog2(MAX_BURST)+1. There is no wrap, because the exit occurs at MAX_BURST-1.

Optional Feature:
- Macro: FIFO_ARB_THRESH_THROTTLE_EN.
- Defined: IDLE does not grant while fifo_thre=1; the pending req waits. A burst already in XFER completes normally.
- Undefined: fifo_thre is ignored (port kept, unused). Arbitration depends only on req and fifo_full.

Decomposition:
- Package fifo_arb_pkg holds:
  - state typedef (IDLE, XFER);
  - default DW/NUM_REQ/MAX_BURST constants;
  - rotate-priority helper function.
- Sub-module rr_pick: combinational round-robin selector with inputs req and rr_last, outputs valid and winner index. It is instantiated once by fifo_push_arbiter.

Test Plan:
- Reset then req=4'b0001, req_last on 3rd word, fifo_full=0 -> gnt=0001 one cycle after req; 3 pushes; back to IDLE; rr_last=0.
- req=4'b1111 held, no req_last, MAX_BURST=4 -> grant order 0,1,2,3,0 with 4 pushes each and a 1-cycle gap between bursts; ack only on owner.
- Owner 2 in XFER, fifo_full forced 1 for 5 cycles mid-burst -> fifo_push=0, ack=0, beat_cnt frozen, gnt held; resumes when full clears; total pushes unchanged.
- rst_n pulsed low during the 2nd beat of owner 1's burst -> gnt, ack and fifo_push go 0 immediately; after release, requester 0 wins the first arbitration.
- Owner drops req after 1 beat -> exit to IDLE next edge with no extra push; next requester is granted after the gap.
- With FIFO_ARB_THRESH_THROTTLE_EN defined, fifo_thre=1 and req=0010 -> no grant until fifo_thre=0, then gnt=0010 next edge. Without the macro, the grant is issued immediately.
